// File: rtl/multi_port_fifo_pkg.sv
// Shared types and helpers for the multi-lane circular FIFO.
// Typedefs reflect the default configuration; the top re-derives widths from its parameters.
package fifo_pkg;

    localparam int unsigned ENTRY_WIDTH_DEF = 32;
    localparam int unsigned N_ENTRIES_DEF   = 8;
    localparam int unsigned PTR_WIDTH_DEF   = $clog2(N_ENTRIES_DEF);
    localparam int unsigned CTR_WIDTH_DEF   = PTR_WIDTH_DEF + 1;
    localparam int unsigned LANES_MAX       = 32;

    typedef logic [ENTRY_WIDTH_DEF-1:0] entry_t;
    typedef logic [PTR_WIDTH_DEF-1:0]   ptr_t;
    typedef logic [CTR_WIDTH_DEF-1:0]   ctr_t;

    // Number of consecutive ones starting at bit 0, looking only at the low n bits.
    function automatic int unsigned leading_ones(input logic [LANES_MAX-1:0] v,
                                                 input int unsigned n);
        int unsigned cnt;
        logic        stop;
        cnt  = 0;
        stop = 1'b0;
        for (int unsigned i = 0; i < LANES_MAX; i++) begin
            if (i < n && !stop) begin
                if (v[i]) cnt++;
                else      stop = 1'b1;
            end
        end
        return cnt;
    endfunction

endpackage

// File: rtl/multi_port_fifo_prefix_count.sv
// Leading-ones counter: how many lanes, from lane 0 upward, are contiguously set.
module prefix_count
    import fifo_pkg::*;
#(
    parameter  int unsigned WIDTH     = 2,
    localparam int unsigned CNT_WIDTH = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0]     vec_i,
    output logic [CNT_WIDTH-1:0] cnt_o
);

    logic [LANES_MAX-1:0] vec_ext;

    always_comb begin
        vec_ext              = '0;
        vec_ext[WIDTH-1:0]   = vec_i;
        cnt_o                = CNT_WIDTH'(leading_ones(vec_ext, WIDTH));
    end

endmodule

// File: rtl/multi_port_fifo.sv
// Multi-lane in-order circular FIFO: up to N_ENQ pushes and N_DEQ pops per cycle.
// All outputs derive from registered state only; internal state is exported for debug.
module multi_port_fifo
    import fifo_pkg::*;
#(
    parameter  int unsigned N_ENTRIES   = 8,
    parameter  int unsigned ENTRY_WIDTH = 32,
    parameter  int unsigned N_ENQ       = 2,
    parameter  int unsigned N_DEQ       = 2,
    localparam int unsigned PTR_WIDTH   = $clog2(N_ENTRIES),
    localparam int unsigned CTR_WIDTH   = PTR_WIDTH + 1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    flush,
    input  logic [N_ENQ-1:0]                        enq_valid,
    input  logic [N_ENQ-1:0][ENTRY_WIDTH-1:0]       enq_data,
    output logic [N_ENQ-1:0]                        enq_ready,
    input  logic [N_DEQ-1:0]                        deq_ready,
    output logic [N_DEQ-1:0]                        deq_valid,
    output logic [N_DEQ-1:0][ENTRY_WIDTH-1:0]       deq_data,
    output logic [CTR_WIDTH-1:0]                    count,
    output logic [N_ENTRIES-1:0][ENTRY_WIDTH-1:0]   current_entry_reg_state,
    output logic [CTR_WIDTH-1:0]                    current_enq_up_counter_state,
    output logic [CTR_WIDTH-1:0]                    current_deq_up_counter_state
);

    localparam int unsigned NE_WIDTH = $clog2(N_ENQ + 1);
    localparam int unsigned ND_WIDTH = $clog2(N_DEQ + 1);

    logic [N_ENTRIES-1:0][ENTRY_WIDTH-1:0] mem_q, mem_d;
    logic [CTR_WIDTH-1:0]                  enq_ctr_q, enq_ctr_d;
    logic [CTR_WIDTH-1:0]                  deq_ctr_q, deq_ctr_d;

    logic [CTR_WIDTH-1:0] free;
    logic [NE_WIDTH-1:0]  n_enq;
    logic [ND_WIDTH-1:0]  n_deq;
    logic [PTR_WIDTH-1:0] rd_ptr;
    logic [PTR_WIDTH-1:0] wr_ptr;

    // Occupancy comes from the counters' difference; the extra wrap bit separates full from empty.
    always_comb begin
        count = enq_ctr_q - deq_ctr_q;
        free  = CTR_WIDTH'(N_ENTRIES) - count;
    end

    always_comb begin
        enq_ready = '0;
        for (int unsigned k = 0; k < N_ENQ; k++) begin
            enq_ready[k] = 32'(free) > k;
        end
    end

    always_comb begin
        deq_valid = '0;
        deq_data  = '0;
        rd_ptr    = '0;
        for (int unsigned k = 0; k < N_DEQ; k++) begin
            rd_ptr       = deq_ctr_q[PTR_WIDTH-1:0] + PTR_WIDTH'(k);
            deq_valid[k] = 32'(count) > k;
            deq_data[k]  = mem_q[rd_ptr];
        end
    end

    prefix_count #(.WIDTH(N_ENQ)) u_enq_count (
        .vec_i (enq_valid & enq_ready),
        .cnt_o (n_enq)
    );

    prefix_count #(.WIDTH(N_DEQ)) u_deq_count (
        .vec_i (deq_valid & deq_ready),
        .cnt_o (n_deq)
    );

    // Flush rewinds both counters but leaves stored data in place and drops this cycle's writes.
    always_comb begin
        mem_d     = mem_q;
        enq_ctr_d = enq_ctr_q + CTR_WIDTH'(n_enq);
        deq_ctr_d = deq_ctr_q + CTR_WIDTH'(n_deq);
        wr_ptr    = '0;
        if (flush) begin
            enq_ctr_d = '0;
            deq_ctr_d = '0;
        end else begin
            for (int unsigned k = 0; k < N_ENQ; k++) begin
                wr_ptr = enq_ctr_q[PTR_WIDTH-1:0] + PTR_WIDTH'(k);
                if (k < 32'(n_enq)) mem_d[wr_ptr] = enq_data[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q     <= '0;
            enq_ctr_q <= '0;
            deq_ctr_q <= '0;
        end else begin
            mem_q     <= mem_d;
            enq_ctr_q <= enq_ctr_d;
            deq_ctr_q <= deq_ctr_d;
        end
    end

    assign current_entry_reg_state      = mem_q;
    assign current_enq_up_counter_state = enq_ctr_q;
    assign current_deq_up_counter_state = deq_ctr_q;

endmodule
